// File: rtl/adc_spi_pkg.sv
// rtl/adc_spi_pkg.sv - shared constants and state type for the ADC SPI responder
package adc_spi_pkg;

  localparam int FRAME_BITS    = 16;
  localparam int ADDR_LSB_RISE = 3;
  localparam int ADDR_MSB_RISE = 5;
  localparam int ZERO_LEAD     = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/adc_spi_responder_if.sv
// rtl/adc_spi_responder_if.sv - SPI bus between the ADC initiator and the responder
interface adc_spi_responder_if;
  logic adc_cs_n;
  logic adc_sclk;
  logic adc_saddr;
  logic adc_sdat;
  logic sdat_oe;

  modport master (
    output adc_cs_n,
    output adc_sclk,
    output adc_saddr,
    input  adc_sdat,
    input  sdat_oe
  );

  modport slave (
    input  adc_cs_n,
    input  adc_sclk,
    input  adc_saddr,
    output adc_sdat,
    output sdat_oe
  );
endinterface

// File: rtl/adc_spi_responder_sync_edge_det.sv
// rtl/adc_spi_responder_sync_edge_det.sv - N-stage synchronizer with rise/fall pulses
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Shift the async input through the chain; prev holds the previous synchronized sample
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
  end

  // Reset to the idle level of the line so no false edge appears after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - emulates an 8-channel 12-bit serial ADC on the SPI pins
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 12,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  adc_spi_responder_if.slave   spi,
  input  logic                 ch_wr_en,
  input  logic [2:0]           ch_wr_addr,
  input  logic [DATA_W-1:0]    ch_wr_data,
  output logic                 frame_done,
  output logic [2:0]           last_ch,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [7:0]           abort_cnt
);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic saddr_lvl, saddr_rise_unused, saddr_fall_unused;

  // CS idles high, SCLK idles high, SADDR idles low
  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(reset_n), .async_in(spi.adc_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .rst_n(reset_n), .async_in(spi.adc_sclk),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_saddr (
    .clk(clk), .rst_n(reset_n), .async_in(spi.adc_saddr),
    .level(saddr_lvl), .rise(saddr_rise_unused), .fall(saddr_fall_unused)
  );

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [4:0]              rise_q, rise_d;
  logic [4:0]              rise_inc;
  logic [2:0]              addr_q, addr_d;
  logic [2:0]              cur_q, cur_d;
  logic [2:0]              next_q, next_d;
  logic [2:0]              last_q, last_d;
  logic [CNT_W-1:0]        fcnt_q, fcnt_d;
  logic [7:0]              acnt_q, acnt_d;
  logic                    done_q, done_d;
  logic                    sdat_q, sdat_d;
  logic                    oe_q, oe_d;
  logic                    frame_end;
  logic [DATA_W-1:0]       regs_q [8];
  logic [DATA_W-1:0]       regs_d [8];

  // Channel register file: a write lands on the next edge, so a same-cycle snapshot sees the old value
  always_comb begin
    regs_d = regs_q;
    if (ch_wr_en) regs_d[ch_wr_addr] = ch_wr_data;
  end

  // Frame sequencing: snapshot at CS fall, shift on SCLK fall, count and capture address on SCLK rise
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    rise_d    = rise_q;
    addr_d    = addr_q;
    cur_d     = cur_q;
    next_d    = next_q;
    last_d    = last_q;
    fcnt_d    = fcnt_q;
    acnt_d    = acnt_q;
    done_d    = 1'b0;
    frame_end = 1'b0;
    rise_inc  = rise_q + 5'd1;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          shift_d = FRAME_BITS'(regs_q[next_q]);
          cur_d   = next_q;
          rise_d  = 5'd0;
        end
      end

      SHIFT: begin
        if (sclk_rise) begin
          rise_d = rise_inc;
          if (rise_inc >= 5'(ADDR_LSB_RISE) && rise_inc <= 5'(ADDR_MSB_RISE)) begin
            addr_d = {addr_q[1:0], saddr_lvl};
          end
          if (rise_inc == 5'(FRAME_BITS)) begin
            frame_end = 1'b1;
            done_d    = 1'b1;
            last_d    = cur_q;
            fcnt_d    = fcnt_q + 1'b1;
            next_d    = addr_d;
            rise_d    = 5'd0;
            // CS still low: the initiator is streaming, so the next frame starts right away
            if (!cs_lvl) begin
              shift_d = FRAME_BITS'(regs_q[addr_d]);
              cur_d   = addr_d;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (sclk_fall && rise_q != 5'd0 && rise_q < 5'(FRAME_BITS)) begin
          // The first fall only precedes rise 1, which samples the MSB already on the pin
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        end

        // A completed frame wins over a coincident CS rise
        if (cs_rise && !frame_end) begin
          state_d = IDLE;
          rise_d  = 5'd0;
          if ((rise_q != 5'd0 || sclk_rise) && acnt_q != 8'hFF) begin
            acnt_d = acnt_q + 8'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    sdat_d = (state_d == SHIFT) ? shift_d[FRAME_BITS-1] : 1'b0;
    oe_d   = (state_d == SHIFT);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      rise_q  <= '0;
      addr_q  <= '0;
      cur_q   <= '0;
      next_q  <= '0;
      last_q  <= '0;
      fcnt_q  <= '0;
      acnt_q  <= '0;
      done_q  <= 1'b0;
      sdat_q  <= 1'b0;
      oe_q    <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      rise_q  <= rise_d;
      addr_q  <= addr_d;
      cur_q   <= cur_d;
      next_q  <= next_d;
      last_q  <= last_d;
      fcnt_q  <= fcnt_d;
      acnt_q  <= acnt_d;
      done_q  <= done_d;
      sdat_q  <= sdat_d;
      oe_q    <= oe_d;
      regs_q  <= regs_d;
    end
  end

  assign spi.adc_sdat = sdat_q;
  assign spi.sdat_oe  = oe_q;
  assign frame_done   = done_q;
  assign last_ch      = last_q;
  assign frame_cnt    = fcnt_q;
  assign abort_cnt    = acnt_q;

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Synthesizable SPI responder that emulates the 8-channel, 12-bit serial ADC read by imu_controller: it consumes ADC_CS_N / ADC_SCLK / ADC_SADDR and drives ADC_SDAT.
- Used for hardware-in-the-loop and bench bring-up: a second board or loopback header feeds known channel codes to the IMU path.
- Channel values are loaded through a simple write port from an Avalon wrapper or the testbench.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on cs_n/sclk/saddr (minimum 2).
- DATA_W, 12, conversion result width; frame length is fixed at DATA_W+4 = 16 SCLK cycles.
- CNT_W, 16, width of frame_cnt.

Ports:
- clk  in  1  system clock, 50 MHz; SCLK must be at most clk/8.
- reset_n  in  1  asynchronous active-low reset.
- adc_cs_n  in  1  chip select from the initiator, active low, asynchronous to clk.
- adc_sclk  in  1  serial clock from the initiator; idles high.
- adc_saddr  in  1  serial address (DIN) from the initiator.
- adc_sdat  out  1  serial data (DOUT) to the initiator.
- sdat_oe  out  1  1 while the synchronized CS is low; external tristate control.
- ch_wr_en  in  1  write strobe for the channel register file.
- ch_wr_addr  in  3  channel index to write.
- ch_wr_data  in  DATA_W  value to return for that channel.
- frame_done  out  1  one-clk pulse per completed 16-bit frame.
- last_ch  out  3  channel served in the most recent completed frame.
- frame_cnt  out  CNT_W  completed frames; wraps modulo 2^CNT_W.
- abort_cnt  out  8  frames aborted by a CS rise mid-frame; saturates at 255.

Behaviour:
- Reset values: adc_sdat=0, sdat_oe=0, frame_done=0, last_ch=0, frame_cnt=0, abort_cnt=0, all channel registers=0, next_ch=0, state=IDLE.
- Synchronization and edge detect:
  - cs_n, sclk and saddr each pass through SYNC_STAGES flops.
  - Rise/fall of sclk and fall/rise of cs_n are detected from the last two synchronized samples.
- States:
  - IDLE: sdat_oe=0, adc_sdat=0.
    - On detected CS fall, go to SHIFT: snapshot shift_reg={4'b0, reg[next_ch]}, cur_ch=next_ch, rise_cnt=0, sdat_oe=1.
  - SHIFT: adc_sdat = shift_reg[15] (registered).
    - Each sclk rise: rise_cnt++. On rises 3, 4, 5 capture saddr into addr_sr (MSB first: ADD2, ADD1, ADD0).
    - Each sclk fall with 1 <= rise_cnt <= 15: shift_reg shifts left by 1 (zero fill).
    - Rise 16 completes the frame: frame_done=1 for one clk, last_ch=cur_ch, frame_cnt++, next_ch=addr_sr.
      - If CS is still low, immediately start a new frame: reload shift_reg from reg[next_ch], cur_ch=next_ch, rise_cnt=0.
      - Continuous back-to-back frames are supported this way.
    - CS rise with rise_cnt < 16: abort; go to IDLE, abort_cnt++ (saturating), next_ch unchanged, no frame_done.
    - CS rise at rise_cnt=0 after a completed frame: normal return to IDLE, no abort.
- Addressing:
  - The address captured in frame N selects the channel returned in frame N+1.
  - The first frame after reset returns channel 0.
  - next_ch persists across CS-high gaps.
- Latency: adc_sdat settles at most SYNC_STAGES+2 clk after the CS fall or sclk fall. At clk/8 SCLK this is inside the initiator's half-period.
- Register file:
  - A write takes effect on the next clk edge.
  - A frame's value is snapshotted at frame start, so mid-frame writes appear from the next frame onward.
  - A write in the same clk as the snapshot to the same channel: the snapshot takes the old value.
- Counter rules: frame_cnt wraps 0xFFFF->0; abort_cnt holds at 255.
- Other boundaries:
  - sclk edges while CS is high are ignored.
  - Reset asserted mid-frame returns everything to reset values immediately.
  - Simultaneous CS rise and sclk rise #16 in the same sample counts as a completed frame, not an abort.

Decomposition:
- Shared package adc_spi_pkg holds:
  - FRAME_BITS=16, ADDR_LSB_RISE=3, ADDR_MSB_RISE=5, ZERO_LEAD=4;
  - state enum {IDLE, SHIFT}.
- One natural sub-module: sync_edge_det (N-stage synchronizer plus rise/fall pulses), instantiated three times.

Test Plan:
- Reset, write reg[0]=0xABC, one 16-clock frame with saddr address 5 -> sdat reads 0x0ABC; frame_done once; last_ch=0; frame_cnt=1.
- Write reg[5]=0x123, second frame with address 2 -> reads 0x0123; last_ch=5; next frame with reg[2]=0xFFF reads 0x0FFF.
- Three back-to-back frames with CS held low, addresses 7, 1, 3 and distinct values -> correct values in order, frame_cnt=3, three frame_done pulses.
- CS raised after 9 rises -> abort_cnt=1, no frame_done, next frame still returns the pre-abort next_ch value.
- ch_wr_en to the active channel at rise 8 with 0x555 (old value 0x0AA) -> current frame reads 0x00AA, the following frame reads 0x0555.
- reset_n pulsed low mid-frame -> adc_sdat=0, sdat_oe=0, counters 0; the next frame returns channel 0.
